// File: rtl/bus_route_decoder.sv
// Routes one arbitrated master request to a single slave and tracks completion.
// Three-state controller (IDLE, DECODE, WAIT) with registered outputs and an optional ack timeout.
module bus_route_decoder #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned NUM_SLAVES  = 3,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SID_W       = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                                                    clk,
    input  logic                                                    rst,
    input  logic [NUM_MASTERS-1:0]                                  m_valid,
    input  logic [NUM_MASTERS*(SID_W+1+ADDR_W+DATA_W)-1:0]          m_req,
    output logic [NUM_MASTERS-1:0]                                  m_ready,
    input  logic [((NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1)-1:0] grant,
    input  logic                                                    grant_valid,
    output logic [ADDR_W-1:0]                                       address_slave,
    output logic [DATA_W-1:0]                                       data,
    output logic [NUM_SLAVES-1:0]                                   wen,
    output logic [NUM_SLAVES-1:0]                                   ren,
    input  logic [NUM_SLAVES-1:0]                                   s_ack,
    output logic                                                    done,
    output logic                                                    err,
    output logic                                                    busy
);

    localparam int unsigned REQ_W  = SID_W + 1 + ADDR_W + DATA_W;
    localparam int unsigned MSEL_W = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DECODE = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;

    logic [1:0]            state, state_d;
    logic [REQ_W-1:0]      cap, cap_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic [CNT_W:0]        cnt_inc;
    logic [NUM_MASTERS-1:0] m_ready_d;
    logic [NUM_SLAVES-1:0] wen_d, ren_d;
    logic [ADDR_W-1:0]     addr_d;
    logic [DATA_W-1:0]     data_d;
    logic                  done_d, err_d, busy_d;

    logic                  grant_ok, sel_valid;
    logic [NUM_MASTERS-1:0] grant_onehot;
    logic [REQ_W-1:0]      sel_req;
    logic [SID_W-1:0]      cap_sid;
    logic                  cap_rw;
    logic                  sid_ok;
    logic [NUM_SLAVES-1:0] sid_onehot;
    logic                  ack_hit;

    assign cap_sid = cap[DATA_W+ADDR_W+1 +: SID_W];
    assign cap_rw  = cap[DATA_W+ADDR_W];
    assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
    // Only the slave currently enabled can complete the transaction.
    assign ack_hit = |(s_ack & (wen | ren));

    // Master selection by grant index; out-of-range grants match nothing.
    always_comb begin
        grant_ok     = 1'b0;
        sel_valid    = 1'b0;
        grant_onehot = '0;
        sel_req      = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (grant == MSEL_W'(i)) begin
                grant_ok        = 1'b1;
                sel_valid       = m_valid[i];
                grant_onehot[i] = 1'b1;
                sel_req         = m_req[i*REQ_W +: REQ_W];
            end
        end
    end

    // Slave decode of the captured sid.
    always_comb begin
        sid_ok     = 1'b0;
        sid_onehot = '0;
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            if (cap_sid == SID_W'(k)) begin
                sid_ok        = 1'b1;
                sid_onehot[k] = 1'b1;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state;
        cap_d     = cap;
        cnt_d     = cnt;
        m_ready_d = '0;
        wen_d     = wen;
        ren_d     = ren;
        addr_d    = address_slave;
        data_d    = data;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid && grant_ok && sel_valid) begin
                    cap_d     = sel_req;
                    m_ready_d = grant_onehot;
                    state_d   = DECODE;
                end
            end
            DECODE: begin
                if (sid_ok) begin
                    addr_d  = cap[DATA_W +: ADDR_W];
                    data_d  = cap[DATA_W-1:0];
                    wen_d   = cap_rw ? sid_onehot : '0;
                    ren_d   = cap_rw ? '0 : sid_onehot;
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (ack_hit) begin
                    wen_d   = '0;
                    ren_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if ((TIMEOUT != 0) && (cnt_inc == (CNT_W+1)'(TIMEOUT))) begin
                    wen_d   = '0;
                    ren_d   = '0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                end
            end
            default: begin
                wen_d   = '0;
                ren_d   = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cap           <= '0;
            cnt           <= '0;
            m_ready       <= '0;
            wen           <= '0;
            ren           <= '0;
            address_slave <= '0;
            data          <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_d;
            cap           <= cap_d;
            cnt           <= cnt_d;
            m_ready       <= m_ready_d;
            wen           <= wen_d;
            ren           <= ren_d;
            address_slave <= addr_d;
            data          <= data_d;
            done          <= done_d;
            err           <= err_d;
            busy          <= busy_d;
        end
    end

endmodule

// File: tb/tb_bus_route_decoder.sv
// Directed bench for bus_route_decoder: 3 masters, 3 slaves, TIMEOUT=4.
module tb_bus_route_decoder;

    localparam int unsigned NM     = 3;
    localparam int unsigned NS     = 3;
    localparam int unsigned AW     = 12;
    localparam int unsigned DW     = 32;
    localparam int unsigned SW     = 2;
    localparam int unsigned REQ_W  = SW + 1 + AW + DW;
    localparam int unsigned MSEL_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NM-1:0]     m_valid;
    logic [NM*REQ_W-1:0] m_req;
    logic [NM-1:0]     m_ready;
    logic [MSEL_W-1:0] grant;
    logic              grant_valid;
    logic [AW-1:0]     address_slave;
    logic [DW-1:0]     data;
    logic [NS-1:0]     wen, ren, s_ack;
    logic              done, err, busy;

    int passed = 0;
    int total  = 0;

    bus_route_decoder #(
        .NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW),
        .DATA_W(DW), .SID_W(SW), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst), .m_valid(m_valid), .m_req(m_req), .m_ready(m_ready),
        .grant(grant), .grant_valid(grant_valid), .address_slave(address_slave),
        .data(data), .wen(wen), .ren(ren), .s_ack(s_ack),
        .done(done), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [REQ_W-1:0] mk(input logic [SW-1:0] sid, input logic rw,
                                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        return {sid, rw, a, d};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int m, input logic [REQ_W-1:0] r);
        m_req[m*REQ_W +: REQ_W] = r;
    endtask

    task automatic drive_grant(input int m);
        m_valid     = NM'(1) << m;
        grant       = MSEL_W'(m);
        grant_valid = 1'b1;
    endtask

    task automatic idle_inputs();
        m_valid     = '0;
        grant_valid = 1'b0;
        grant       = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, {m_ready, wen, ren, done, err, busy}, 64'd0);
        chk({tag, "_addr"}, address_slave, 64'd0);
        chk({tag, "_data"}, data, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        m_req = '0;
        s_ack = '0;
        idle_inputs();
        #12;
        chk_all_zero("reset");
        rst = 1'b0;
        step();

        // Master1 write to slave 0
        set_req(1, mk(2'd0, 1'b1, 12'h0A5, 32'hDEADBEEF));
        drive_grant(1);
        step();
        chk("a_mready", m_ready, 64'b010);
        chk("a_busy", busy, 64'd1);
        chk("a_wen_accept", wen, 64'd0);
        idle_inputs();
        step();
        chk("a_mready_off", m_ready, 64'd0);
        chk("a_wen", wen, 64'b001);
        chk("a_addr", address_slave, 64'h0A5);
        chk("a_data", data, 64'hDEADBEEF);
        step();
        chk("a_wen_hold", wen, 64'b001);
        chk("a_done_early", done, 64'd0);
        s_ack = 3'b001;
        step();
        s_ack = '0;
        chk("a_done", {done, err, wen}, {59'd0, 1'b1, 1'b0, 3'b000});
        chk("a_busy_end", busy, 64'd0);

        // Back-to-back master0 read of slave 2, stray ack on slave 1
        set_req(0, mk(2'd2, 1'b0, 12'h123, 32'h11112222));
        drive_grant(0);
        step();
        chk("b_mready", m_ready, 64'b001);
        idle_inputs();
        step();
        chk("b_en", {wen, ren}, {58'd0, 3'b000, 3'b100});
        chk("b_data", data, 64'h11112222);
        s_ack = 3'b010;
        step();
        chk("b_ignore", {done, ren}, {60'd0, 1'b0, 3'b100});
        s_ack = 3'b100;
        step();
        s_ack = '0;
        chk("b_done", {done, err, ren}, {59'd0, 1'b1, 1'b0, 3'b000});

        // Master2 to nonexistent slave 3
        set_req(2, mk(2'd3, 1'b1, 12'h777, 32'h00000055));
        drive_grant(2);
        step();
        chk("c_mready", m_ready, 64'b100);
        idle_inputs();
        step();
        chk("c_err", {done, err, wen, ren}, {56'd0, 1'b1, 1'b1, 3'b000, 3'b000});
        chk("c_addr_hold", address_slave, 64'h123);
        chk("c_data_hold", data, 64'h11112222);
        step();
        chk("c_idle", {done, err, busy}, 64'd0);

        // Timeout with no ack: enable high exactly 4 WAIT cycles
        set_req(0, mk(2'd1, 1'b1, 12'h200, 32'h0000000A));
        drive_grant(0);
        step();
        idle_inputs();
        step();
        chk("d_wen_c1", wen, 64'b010);
        for (int c = 2; c <= 4; c++) begin
            step();
            chk($sformatf("d_wen_c%0d", c), {done, wen}, {60'd0, 1'b0, 3'b010});
        end
        step();
        chk("d_timeout", {done, err, wen}, {59'd0, 1'b1, 1'b1, 3'b000});

        // Ack on the timeout cycle wins
        drive_grant(0);
        step();
        idle_inputs();
        step();
        step();
        step();
        step();
        chk("e_wen_c4", wen, 64'b010);
        s_ack = 3'b010;
        step();
        s_ack = '0;
        chk("e_ack_wins", {done, err, wen}, {59'd0, 1'b1, 1'b0, 3'b000});

        // Reset in the middle of WAIT
        set_req(1, mk(2'd0, 1'b0, 12'h0F0, 32'hCAFEF00D));
        drive_grant(1);
        step();
        idle_inputs();
        step();
        step();
        chk("f_ren", ren, 64'b001);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("f_async");
        #1 rst = 1'b0;
        step();
        chk("f_no_done", {done, err, busy}, 64'd0);
        m_valid = 3'b111;
        grant = 2'd3;
        grant_valid = 1'b1;
        step();
        chk("f_bad_grant", {m_ready, busy}, 64'd0);
        grant = 2'd1;
        grant_valid = 1'b0;
        step();
        chk("f_no_gv", {m_ready, busy}, 64'd0);
        grant_valid = 1'b1;
        step();
        chk("f_accept", m_ready, 64'b010);
        idle_inputs();
        step();
        chk("f_ren_after", ren, 64'b001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bus_route_decoder.md
BUS_ROUTE_DECODER -- requirements
Module: bus_route_decoder

Interface
REQ-001 Parameter NUM_MASTERS, default 2: request ports; legal 2..8.
REQ-002 Parameter NUM_SLAVES, default 3: slave ports; legal 1..8.
REQ-003 Parameter ADDR_W, default 12: slave address width.
REQ-004 Parameter DATA_W, default 32: write data width.
REQ-005 Parameter SID_W, default 2: slave-id field width; 2**SID_W >= NUM_SLAVES.
REQ-006 Parameter TIMEOUT, default 255: maximum wait cycles for a slave ack; 0 disables the timeout.
REQ-007 Derived: REQ_W = SID_W+1+ADDR_W+DATA_W; MSEL_W = max(1,clog2(NUM_MASTERS)).
REQ-008 Reset is rst, asynchronous, active-high; clock is clk.
REQ-009 clk  in  1  rising-edge clock.
REQ-010 rst  in  1  asynchronous active-high reset.
REQ-011 m_valid  in  NUM_MASTERS  per-master request valid.
REQ-012 m_req  in  NUM_MASTERS*REQ_W  packed requests; master i at bits [i*REQ_W +: REQ_W], each {sid, rw(1=write), addr, data}.
REQ-013 m_ready  out  NUM_MASTERS  one-cycle one-hot accept pulse to the granted master.
REQ-014 grant  in  MSEL_W  master index from the arbiter.
REQ-015 grant_valid  in  1  grant qualifier.
REQ-016 address_slave  out  ADDR_W  registered slave address.
REQ-017 data  out  DATA_W  registered write data.
REQ-018 wen / ren  out  NUM_SLAVES each  one-hot write/read enables, bit k = slave k.
REQ-019 s_ack  in  NUM_SLAVES  per-slave completion strobe.
REQ-020 done  out  1  one-cycle pulse at transaction end; err  out  1  one-cycle pulse, qualifies done as failed; busy  out  1  high when not IDLE.

Function
REQ-021 FSM states IDLE, DECODE, WAIT; all outputs registered.
REQ-022 IDLE: when grant_valid=1, grant<NUM_MASTERS and m_valid[grant]=1, capture m_req slice of master grant, pulse m_ready[grant] for one cycle, go to DECODE.
REQ-023 IDLE: grant >= NUM_MASTERS, grant_valid=0 or m_valid[grant]=0 -> no capture, m_ready stays 0.
REQ-024 Requests are never accepted outside IDLE; m_ready is 0 in DECODE and WAIT.
REQ-025 DECODE, sid < NUM_SLAVES: load address_slave/data from the capture, assert wen[sid] if rw=1 else ren[sid], all other enables 0, go to WAIT.
REQ-026 DECODE, sid >= NUM_SLAVES: no enables, address_slave/data unchanged, pulse done and err, return to IDLE.
REQ-027 Latency: enables are high the cycle after the m_ready pulse (one edge after accept, two edges after request input is valid).
REQ-028 WAIT: enable held constant; s_ack[sid]=1 -> clear enables, pulse done (err=0), return to IDLE next cycle.
REQ-029 s_ack bits of non-addressed slaves are ignored in all states.
REQ-030 Wait counter clears on entry to WAIT and increments each WAIT cycle without ack; at count = TIMEOUT (TIMEOUT>0) clear enables, pulse done and err, return to IDLE.
REQ-031 Ack on the same cycle as timeout: ack wins, err=0.
REQ-032 address_slave and data hold their last value between transactions.
REQ-033 Back-to-back: a new request is acceptable on the first IDLE cycle after done; minimum 3 cycles per transaction.

Reset
REQ-034 rst=1 asynchronously forces IDLE, wait counter 0, capture register 0, and m_ready, wen, ren, address_slave, data, done, err, busy all 0.
REQ-035 Reset during DECODE or WAIT abandons the transaction with no done/err pulse; the first request after release is accepted normally.

Verification
REQ-036 Master1 req {sid=0,rw=1,addr=0x0A5,data=0xDEADBEEF}, grant=1 -> m_ready=0b10 one cycle, next cycle wen=0b001, address_slave=0x0A5, data=0xDEADBEEF; s_ack[0] two cycles later -> done=1, err=0, wen=0.
REQ-037 Master0 read sid=2 -> ren=0b100 only; s_ack[1] asserted first is ignored, s_ack[2] ends it with done=1.
REQ-038 sid=3 with NUM_SLAVES=3 -> no enables, done=1 and err=1 on the cycle after accept, address_slave/data unchanged.
REQ-039 TIMEOUT=4, no ack -> enable high exactly 4 WAIT cycles then cleared with done=1, err=1; repeat with ack on cycle 4 -> err=0.
REQ-040 rst pulsed mid-WAIT -> all outputs 0 immediately, no done; after release a grant_valid with grant=NUM_MASTERS is ignored, then a legal grant is accepted.
